// File: rtl/voice_allocator.sv
// voice_allocator: queues key rises and assigns one-shot notes of TMAX ticks to NVOICE voices (retrigger, idle, or steal oldest)
module voice_allocator #(
  parameter int NVOICE = 4,
  parameter int TMAX = 15625
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   en,
  input  logic [11:0]            keys,
  output logic [NVOICE-1:0]      voice_active,
  output logic [4*NVOICE-1:0]    voice_key,
  output logic [14*NVOICE-1:0]   voice_time,
  output logic [NVOICE-1:0]      voice_start,
  output logic                   steal,
  output logic                   busy
);
  logic [11:0] keys_q, pending, rise, svc, pend_n;
  logic [3:0] k;
  logic req, stl;
  logic [NVOICE-1:0] hit, idle, sel;
  int oi;
  always_comb begin
    rise = keys & ~keys_q;
    svc = pending & (~pending + 12'd1);
    k = '0;
    for (int i = 11; i >= 0; i--) if (pending[i]) k = 4'(i);
    req = |pending;
    pend_n = (pending & ~svc) | (en ? rise : '0);
  end
  always_comb begin
    hit = '0;
    for (int v = 0; v < NVOICE; v++) hit[v] = voice_active[v] && voice_key[4*v +: 4] == k;
    idle = ~voice_active;
    oi = 0;
    for (int v = 1; v < NVOICE; v++) if (voice_time[14*v +: 14] > voice_time[14*oi +: 14]) oi = v;
    sel = |hit ? hit & (~hit + NVOICE'(1)) : |idle ? idle & (~idle + NVOICE'(1)) : NVOICE'(1) << oi;
    stl = ~|hit & ~|idle;
  end
  always_ff @(posedge clk) begin
    keys_q <= keys;
    if (reset) begin
      pending <= '0;
      busy <= 1'b0;
      voice_active <= '0;
      voice_key <= '0;
      voice_time <= '0;
      voice_start <= '0;
      steal <= 1'b0;
    end else begin
      pending <= pend_n;
      busy <= |pend_n;
      voice_start <= req ? sel : '0;
      steal <= req & stl;
      for (int v = 0; v < NVOICE; v++) begin
        if (req && sel[v]) begin
          voice_active[v] <= 1'b1;
          voice_key[4*v +: 4] <= k;
          voice_time[14*v +: 14] <= '0;
        end else if (tick && voice_active[v]) begin
          if (voice_time[14*v +: 14] == 14'(TMAX-1)) begin
            voice_active[v] <= 1'b0;
            voice_time[14*v +: 14] <= '0;
          end else voice_time[14*v +: 14] <= voice_time[14*v +: 14] + 14'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table vectors and corner-case sequences checked through an expectation queue
module tb_voice_allocator;
  localparam int TMAX = 15625;
  logic clk = 0, reset = 1, tick = 0, en = 0;
  logic [11:0] keys = '0;
  logic [3:0] voice_active, voice_start;
  logic [15:0] voice_key;
  logic [55:0] voice_time;
  logic steal, busy;
  voice_allocator #(.NVOICE(4), .TMAX(TMAX)) dut (
    .clk(clk), .reset(reset), .tick(tick), .en(en), .keys(keys),
    .voice_active(voice_active), .voice_key(voice_key), .voice_time(voice_time),
    .voice_start(voice_start), .steal(steal), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {string name; int fld; logic [63:0] exp;} exp_t;
  typedef struct {logic [11:0] k; logic e; logic t; logic [3:0] act; logic [15:0] key; logic [55:0] tm; logic [3:0] st; logic sl; logic b;} vec_t;
  exp_t q[$];
  exp_t cur;
  vec_t tv[13];
  int checks = 0, failures = 0;
  function automatic logic [63:0] got(int f);
    return f == 0 ? 64'(voice_active) : f == 1 ? 64'(voice_key) : f == 2 ? 64'(voice_time) :
           f == 3 ? 64'(voice_start) : f == 4 ? 64'(steal) : 64'(busy);
  endfunction
  function automatic logic [55:0] t4(int a, int b, int c, int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction
  always @(negedge clk) while (q.size() > 0) begin
    cur = q.pop_front();
    checks++;
    if (got(cur.fld) !== cur.exp) begin
      failures++;
      $display("FAIL %s field%0d: got %0h expected %0h", cur.name, cur.fld, got(cur.fld), cur.exp);
    end
  end
  task automatic check_now(input string n, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, g, e);
    end
  endtask
  task automatic step(input logic [11:0] k, input logic e, input logic t, input logic r);
    @(negedge clk);
    #1;
    keys = k;
    en = e;
    tick = t;
    reset = r;
  endtask
  task automatic want(input string n, input int f, input logic [63:0] v);
    q.push_back('{n, f, v});
  endtask
  task automatic want_all(input string n, input logic [3:0] a, input logic [15:0] k, input logic [55:0] t, input logic [3:0] s, input logic sl, input logic b);
    want(n, 0, 64'(a));
    want(n, 1, 64'(k));
    want(n, 2, 64'(t));
    want(n, 3, 64'(s));
    want(n, 4, 64'(sl));
    want(n, 5, 64'(b));
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(12'h000, 1'b1, 1'b1, 1'b0);
  endtask
  initial begin
    tv[0]  = '{12'h008, 1, 0, 4'h0, 16'h0000, t4(0,0,0,0), 4'h0, 0, 1};
    tv[1]  = '{12'h008, 1, 0, 4'h1, 16'h0003, t4(0,0,0,0), 4'h1, 0, 0};
    tv[2]  = '{12'h008, 1, 1, 4'h1, 16'h0003, t4(1,0,0,0), 4'h0, 0, 0};
    tv[3]  = '{12'h000, 1, 0, 4'h1, 16'h0003, t4(1,0,0,0), 4'h0, 0, 0};
    tv[4]  = '{12'h024, 1, 0, 4'h1, 16'h0003, t4(1,0,0,0), 4'h0, 0, 1};
    tv[5]  = '{12'h024, 1, 0, 4'h3, 16'h0023, t4(1,0,0,0), 4'h2, 0, 1};
    tv[6]  = '{12'h024, 1, 0, 4'h7, 16'h0523, t4(1,0,0,0), 4'h4, 0, 0};
    tv[7]  = '{12'h000, 0, 0, 4'h7, 16'h0523, t4(1,0,0,0), 4'h0, 0, 0};
    tv[8]  = '{12'h800, 0, 0, 4'h7, 16'h0523, t4(1,0,0,0), 4'h0, 0, 0};
    tv[9]  = '{12'h800, 0, 0, 4'h7, 16'h0523, t4(1,0,0,0), 4'h0, 0, 0};
    tv[10] = '{12'h000, 1, 0, 4'h7, 16'h0523, t4(1,0,0,0), 4'h0, 0, 0};
    tv[11] = '{12'h008, 1, 1, 4'h7, 16'h0523, t4(2,1,1,0), 4'h0, 0, 1};
    tv[12] = '{12'h008, 1, 1, 4'h7, 16'h0523, t4(0,2,2,0), 4'h1, 0, 0};
    step(12'h000, 0, 0, 1);
    want_all("reset", 4'h0, 16'h0, '0, 4'h0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step(tv[i].k, tv[i].e, tv[i].t, 0);
      if (i == 0) check_now("reset_direct", {voice_active, voice_key, voice_start, steal, busy}, '0);
      want_all($sformatf("vec%0d", i), tv[i].act, tv[i].key, tv[i].tm, tv[i].st, tv[i].sl, tv[i].b);
    end
    step(12'h000, 0, 0, 1);
    step(12'h00F, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(12'h00F, 1, 0, 0);
    want_all("fill4", 4'hF, 16'h3210, '0, 4'h8, 0, 0);
    ticks(850);
    step(12'h002, 1, 0, 0);
    step(12'h002, 1, 0, 0);
    want("retrig1_start", 3, 64'h2);
    want("retrig1_steal", 4, 64'h0);
    ticks(40);
    step(12'h008, 1, 0, 0);
    step(12'h008, 1, 0, 0);
    want("retrig3_start", 3, 64'h8);
    ticks(10);
    want("times_before_steal", 2, 64'(t4(900, 50, 900, 10)));
    step(12'h800, 1, 0, 0);
    step(12'h800, 1, 0, 0);
    want_all("steal", 4'hF, 16'h321B, t4(0, 50, 900, 10), 4'h1, 1, 0);
    step(12'h000, 1, 0, 0);
    want("steal_one_cycle", 4, 64'h0);
    want("start_one_cycle", 3, 64'h0);
    step(12'h000, 0, 0, 1);
    step(12'h008, 1, 0, 0);
    step(12'h008, 1, 0, 0);
    want("v0_alloc", 0, 64'h1);
    ticks(TMAX - 2);
    step(12'h000, 1, 1, 0);
    want("at_tmax1_time", 2, 64'(t4(TMAX - 1, 0, 0, 0)));
    want("at_tmax1_act", 0, 64'h1);
    step(12'h000, 1, 1, 0);
    want_all("expire", 4'h0, 16'h0003, '0, 4'h0, 0, 0);
    step(12'h008, 1, 0, 0);
    check_now("expire_direct", {voice_active, voice_time}, '0);
    step(12'h008, 1, 0, 0);
    ticks(100);
    want("time100", 2, 64'(t4(100, 0, 0, 0)));
    step(12'h008, 1, 0, 0);
    step(12'h008, 1, 0, 0);
    want_all("retrig_at100", 4'h1, 16'h0003, '0, 4'h1, 0, 0);
    step(12'h000, 0, 0, 1);
    step(12'h010, 1, 0, 0);
    step(12'h010, 1, 0, 0);
    ticks(10);
    step(12'h020, 1, 0, 0);
    step(12'h020, 1, 0, 0);
    ticks(TMAX - 12);
    step(12'h000, 1, 1, 0);
    want("pre_coincide_time", 2, 64'(t4(TMAX - 1, TMAX - 11, 0, 0)));
    step(12'h010, 1, 0, 0);
    step(12'h010, 1, 1, 0);
    want_all("coincide", 4'h3, 16'h0054, t4(0, TMAX - 10, 0, 0), 4'h1, 0, 0);
    step(12'h000, 0, 0, 1);
    step(12'h0F0, 1, 0, 0);
    want("pend_f0_busy", 5, 64'h1);
    step(12'h0F0, 1, 0, 1);
    want_all("reset_midalloc", 4'h0, 16'h0, '0, 4'h0, 0, 0);
    step(12'h080, 1, 0, 0);
    want_all("held_no_req", 4'h0, 16'h0, '0, 4'h0, 0, 0);
    step(12'h080, 1, 0, 0);
    want("held_no_req2", 5, 64'h0);
    step(12'h000, 1, 0, 0);
    step(12'h080, 1, 0, 0);
    want("rerise_busy", 5, 64'h1);
    step(12'h080, 1, 0, 0);
    want_all("rerise_alloc", 4'h1, 16'h0007, '0, 4'h1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NVOICE, default 4: number of voice slots (oscillator/envelope channel pairs).
REQ-002 Parameter TMAX, default 15625: note duration in sample ticks (1 s at 15625 Hz).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  sample strobe, one clk wide, 15625 Hz.
REQ-006 en  input  1  capture enable; 0 blocks new note requests.
REQ-007 keys  input  12  key levels, already synchronous to clk.
REQ-008 voice_active  output  NVOICE  per-voice busy flag.
REQ-009 voice_key  output  4*NVOICE  key index 0..11 owned by each voice; voice v uses bits [4v+3:4v].
REQ-010 voice_time  output  14*NVOICE  per-voice elapsed ticks; voice v uses bits [14v+13:14v]; drives the envelope phase.
REQ-011 voice_start  output  NVOICE  one-clk pulse when a voice is allocated or retriggered.
REQ-012 steal  output  1  one-clk pulse when allocation evicts an active voice.
REQ-013 busy  output  1  high while any key request is pending.

Function
REQ-014 keys_q SHALL register keys every cycle; rise[k] = keys[k] & ~keys_q[k].
REQ-015 When en=1, rise[k] SHALL set pending[k] at the next edge; when en=0, rises SHALL be discarded.
REQ-016 Key releases SHALL NOT affect any voice; every note is one-shot, lasting TMAX ticks.
REQ-017 Each cycle with pending!=0, the lowest-index pending key SHALL be serviced, one key per cycle; its pending bit SHALL clear at that edge.
REQ-018 If a rise on the same key occurs in the cycle it is serviced, set SHALL win and pending SHALL stay 1.
REQ-019 Allocation priority, first match wins: (a) an active voice already owning the key is retriggered; (b) the lowest-index inactive voice; (c) the active voice with the largest voice_time, lowest index on ties, which is stolen.
REQ-020 Allocated voice: voice_active=1, voice_key=k, voice_time=0, voice_start[v] pulses; steal pulses in case (c) only.
REQ-021 Latency: keys[k] first sampled high at edge E0 sets pending; servicing with an empty queue SHALL update the voice outputs at E1.
REQ-022 On tick=1, every active voice not being allocated in that cycle SHALL increment voice_time.
REQ-023 An active voice with voice_time==TMAX-1 on tick SHALL go inactive, with voice_time=0 and voice_key unchanged.
REQ-024 When allocation and tick or expiry hit the same voice in one cycle, allocation SHALL win: time=0, active=1.
REQ-025 voice_time SHALL never exceed TMAX-1; inactive voices SHALL hold voice_time=0.
REQ-026 busy SHALL equal |pending, registered.
REQ-027 voice_start and steal SHALL be 0 in every cycle without an allocation.

Reset
REQ-028 With reset=1 at an edge: voice_active=0, voice_key=0, voice_time=0, voice_start=0, steal=0, pending=0, busy=0.
REQ-029 During reset, keys_q SHALL load keys, so keys held through reset do not create requests.
REQ-030 Reset SHALL take precedence over tick, en and pending requests, including mid-allocation.

Verification
REQ-031 Key 3 rises with en=1 and all voices idle -> 2 edges later voice 0 active, key=3, time=0, voice_start=0001, steal=0.
REQ-032 Keys 5 and 2 rise in the same cycle -> key 2 goes to voice 0 at E1, key 5 to voice 1 at E2, busy high for 2 cycles.
REQ-033 Voice 0 owns key 3 and reaches TMAX-1 ticks -> on the next tick voice_active[0]=0 and time=0; key 3 retriggered at time 100 -> time returns to 0 with no steal.
REQ-034 All 4 voices active with times 900, 50, 900, 10 and key 11 rises -> voice 0 stolen, key=11, steal=1 for one cycle.
REQ-035 Allocation coincides with tick and with expiry of the target voice -> target time=0, active=1; other active voices increment by 1.
REQ-036 Assert reset while pending=0x0F0 with key 7 held -> all outputs 0; after release, no request for key 7 until it falls and rises again.
